// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, oversampling constants and
// the parity helper used by both the receiver and the transmitters.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    // Tick index of the bit centre within the start bit, and of the
    // following bit centres once the sample counter has been realigned.
    localparam logic [3:0] OVS_MID  = 4'd7;
    localparam logic [3:0] OVS_LAST = 4'd15;

    // Parity bit value that makes XOR(data, bit) equal to odd.
    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead FIFO: the head entry is always visible on rdata,
// zero when empty. A pop and a push in the same cycle both succeed when full.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_pop;
    logic             do_push;

    // Extra pointer bit separates the full case from the empty case.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Storage write; contents need no reset because empty masks the output.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    // Pointer update, wrapping modulo DEPTH with the extra lap bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// 16x-oversampling UART receiver: input synchronizer, tick generator,
// frame FSM, sticky error flags and a show-ahead receive FIFO.
// Read handshake: rx_valid means the head entry on rx_data is valid; rd high
// on a clock edge while rx_valid pops it, and rd while empty is ignored.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int OVS        = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] div,
    input  logic        parity_en,
    input  logic        parity_odd,
    input  logic        int_en,
    input  logic        RxD,
    input  logic        rd,
    input  logic        err_clr,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_full,
    output logic        parity_err,
    output logic        frame_err,
    output logic        overrun,
    output logic        INT,
    output logic [2:0]  fsm_state
);
    localparam int SW = $clog2(OVS);

    rx_state_t     state;
    logic          rxd_meta;
    logic          rxd_sync;
    logic          rxd_prev;
    logic          fall;
    logic [15:0]   tick_cnt;
    logic          tick;
    logic [SW-1:0] samp_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          parity_bad;
    logic          push;
    logic          fifo_empty;
    logic          fifo_full;

    assign fall      = rxd_prev & ~rxd_sync;
    assign tick      = en && (state != IDLE) && (tick_cnt == div);
    assign push      = tick && (state == STOP) && (samp_cnt == SW'(OVS_LAST));
    assign rx_valid  = ~fifo_empty;
    assign rx_full   = fifo_full;
    assign INT       = int_en & (rx_valid | parity_err | frame_err | overrun);
    assign fsm_state = state;

    // Two-flop synchronizer plus one history flop for start-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= RxD;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    // Tick divider: held at zero while idle or disabled so a frame starts phase-aligned.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else if (!en || state == IDLE || tick_cnt == div) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 16'd1;
        end
    end

    // Frame FSM: start qualification, LSB-first data capture, parity check, stop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            samp_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            parity_bad <= 1'b0;
        end else if (!en) begin
            state    <= IDLE;
            samp_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fall) begin
                        state      <= START;
                        samp_cnt   <= '0;
                        bit_cnt    <= '0;
                        parity_bad <= 1'b0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (samp_cnt == SW'(OVS_MID)) begin
                            // Realign so later bit centres fall on OVS_LAST.
                            samp_cnt <= '0;
                            state    <= rxd_sync ? IDLE : DATA;
                        end else begin
                            samp_cnt <= samp_cnt + SW'(1);
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        samp_cnt <= samp_cnt + SW'(1);
                        if (samp_cnt == SW'(OVS_LAST)) begin
                            shift   <= {rxd_sync, shift[7:1]};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state <= parity_en ? PARITY : STOP;
                            end
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        samp_cnt <= samp_cnt + SW'(1);
                        if (samp_cnt == SW'(OVS_LAST)) begin
                            parity_bad <= (rxd_sync != parity_bit(shift, parity_odd));
                            state      <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        samp_cnt <= samp_cnt + SW'(1);
                        // Leave at mid-stop so a following start edge is not missed.
                        if (samp_cnt == SW'(OVS_LAST)) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky error flags; a set event in the same cycle as err_clr wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (err_clr) begin
                parity_err <= 1'b0;
                frame_err  <= 1'b0;
                overrun    <= 1'b0;
            end
            if (push && parity_bad)         parity_err <= 1'b1;
            if (push && !rxd_sync)          frame_err  <= 1'b1;
            if (push && fifo_full && !rd)   overrun    <= 1'b1;
        end
    end

    uart_rx_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(8)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (rd),
        .wdata(shift),
        .rdata(rx_data),
        .empty(fifo_empty),
        .full (fifo_full)
    );

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Stand-alone 16x-oversampling UART receiver with a small show-ahead receive FIFO, error flags and interrupt. It is the receive-side counterpart for any of the SoC's UART transmitters. It decodes 8-bit LSB-first frames with optional odd/even parity. It replaces the free-running baud clock with a single-clock tick enable, so all logic runs on `clk`.

## Interface
- `FIFO_DEPTH`, default 4: receive FIFO entries; power of two, minimum 2.
- `OVS`, default 16: oversampling ticks per bit; fixed at 16 for this release.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `en` in 1: receiver enable; low forces IDLE, FIFO contents retained.
- `div` in 16: tick period in clk cycles minus 1 (tick every `div+1` clocks; bit time = 16*(div+1) clocks).
- `parity_en` in 1: a parity bit follows the data bits.
- `parity_odd` in 1: 1 = odd parity, 0 = even parity.
- `int_en` in 1: interrupt enable.
- `RxD` in 1: serial input, idle high, asynchronous.
- `rd` in 1: pop FIFO head; ignored when empty.
- `err_clr` in 1: clears all sticky error flags.
- `rx_data` out 8: FIFO head (show-ahead); 0 when empty.
- `rx_valid` out 1: FIFO not empty.
- `rx_full` out 1: FIFO full.
- `parity_err`, `frame_err`, `overrun` out 1 each: sticky error flags.
- `INT` out 1: `int_en & (rx_valid | parity_err | frame_err | overrun)`.

## Operation
- `RxD` passes through a 2-flop synchronizer; reset value of both flops is 1.
- Tick counter counts 0..`div`, pulses `tick` on wrap. It runs only while `en` is high and is cleared in IDLE.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: a falling edge on synced RxD moves to START, clears the tick and sample counters.
- START: at sample count 7 (mid-bit), RxD=0 moves to DATA; RxD=1 is a glitch and returns to IDLE with no flag.
- DATA: samples once per 16 ticks at mid-bit and shifts right into the shift register (LSB first). After the 8th bit, go to PARITY if `parity_en`, else STOP.
- PARITY: at mid-bit, compute XOR(data, sampled bit). A mismatch against `parity_odd` (XOR must equal `parity_odd`) marks the frame parity-bad.
- STOP: at mid-bit, RxD=0 sets `frame_err`. The byte is pushed in every case (sets `parity_err` if marked). FSM returns to IDLE immediately, so a start edge during the second half of the stop bit is detected.
- A push while full drops the byte and sets `overrun`, unless `rd` is asserted in the same cycle; then pop and push both succeed.
- A pop while empty has no effect.
- `err_clr` clears the flags. If a set event coincides with `err_clr`, the set wins.
- `en` deasserting mid-frame aborts the frame: no push, no flag.
- Changing `div`, `parity_en` or `parity_odd` mid-frame is undefined; software changes them only while idle.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `rx_full`=0, all error flags 0, `INT`=0, FSM=IDLE, FIFO empty.
- Input latency: 2 clk from an RxD edge to the synced value.
- Push happens on the clk edge of the STOP mid-bit tick. `rx_valid` and the flags are visible the following cycle.
- Pop: `rd` sampled high on a clk edge; the next entry or `rx_valid`=0 is visible after that edge.
- `INT` is combinational from the registered flags.
- FIFO pointers wrap modulo `FIFO_DEPTH`; an extra pointer bit distinguishes full from empty.

## Structure
- Shared package `uart_pkg`: FSM state enum, `OVS_MID`=7, `OVS_LAST`=15, and a parity function reused by the transmitter.
- Sub-module `uart_rx_fifo`: synchronous show-ahead FIFO (push, pop, data, empty, full), parameterized by depth and width.
- FSM, tick generator, synchronizer and flags live in `uart_rx_core`.

## Test plan
- `div`=5, no parity, send 0xA5 at 96 clk/bit -> `rx_valid` rises one cycle after the stop mid-bit; `rx_data`=0xA5; no flags set.
- `parity_en`=1, `parity_odd`=1: send 0x03 with parity bit 1 -> accepted. Send 0x03 with parity bit 0 -> byte pushed, `parity_err`=1. With `int_en`=1, `INT`=1 until `err_clr` and pop.
- Stop bit driven 0 on 0x7E -> `frame_err`=1, `rx_data`=0x7E.
- 0-pulse on RxD 4 ticks long -> FSM returns to IDLE, FIFO empty, no flags.
- 5 back-to-back bytes 0x01..0x05 with no `rd`, depth 4 -> `rx_full`=1, `overrun`=1, FIFO holds 0x01..0x04. Repeat with `rd` pulsed on the 5th push cycle -> no overrun, FIFO holds 0x02..0x05.
- Drive `rst` low mid-DATA, then release -> all outputs at reset values; the next full frame 0x5A is received correctly.
